// File: rtl/camera_pkg.sv
// camera_pkg: writer FSM states, packed RGB word field positions and Bayer phase constants
package camera_pkg;
    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, DONE} state_t;
    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;
    localparam logic ROW_GR = 1'b0;
    localparam logic ROW_BG = 1'b1;
    localparam logic COL_ODD = 1'b1;
endpackage

// File: rtl/bayer_line_buffer.sv
// bayer_line_buffer: one line of (G1, R) pairs held for the following B/G2 row
module bayer_line_buffer #(
    parameter int FRAME_W = 320,
    parameter int AW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);
    logic [15:0] r_mem [FRAME_W];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/bayer_frame_writer.sv
// bayer_frame_writer: Bayer quads packed to RGB words, buffered and written to DDR with AGC channel sums
module bayer_frame_writer
    import camera_pkg::*;
#(
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 240,
    parameter int PIX_BITS   = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 20,
    parameter int SUM_W      = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                grab_enable,
    input  logic                pix_valid,
    input  logic                pix_sof,
    input  logic                pix_eol,
    input  logic [PIX_BITS-1:0] pix_data,
    input  logic                pause,
    input  logic [ADDR_W-1:0]   data_write_offset,
    output logic [ADDR_W-1:0]   ddr_addr,
    output logic [31:0]         ddr_data_write,
    output logic                ddr_wren,
    output logic                grab_done,
    output logic                frame_err,
    output logic [SUM_W-1:0]    sum_r,
    output logic [SUM_W-1:0]    sum_g,
    output logic [SUM_W-1:0]    sum_b,
    output logic                sums_valid
);
    localparam int CW   = $clog2(2 * FRAME_W + 1);
    localparam int RW   = $clog2(2 * FRAME_H + 1);
    localparam int LBW  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int NQ   = FRAME_W * FRAME_H;
    localparam int PW   = $clog2(NQ + 1);
    localparam int FAW  = $clog2(FIFO_DEPTH);
    localparam int CNTW = FAW + 1;

    state_t            r_state;
    logic              r_ge_d, r_done, r_err, r_push_v, r_sums_valid, r_wren;
    logic [31:0]       r_push_word, r_ddr_data;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [PW-1:0]     r_pcnt;
    logic [ADDR_W-1:0] r_offset, r_wcnt, r_ddr_addr;
    logic [7:0]        r_evn;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [FAW-1:0]    r_rd, r_wr;
    logic [CNTW-1:0]   r_cnt;
    logic [SUM_W-1:0]  r_acc_r, r_acc_g, r_acc_b, r_sum_r, r_sum_g, r_sum_b;
    logic [15:0]       w_lb_rdata;
    logic [7:0]        w_pix;
    logic              w_take, w_esof, w_col_in, w_row_in, w_quad, w_lb_we;
    logic              w_pop, w_full, w_wr, w_ovf, w_unused;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [7:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W + 1)'(b);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    assign w_pix    = pix_data[PIX_BITS-1 -: 8];
    assign w_unused = ^pix_data[PIX_BITS-9:0];
    // The sof sample itself is taken in ARM; a later sof in CAPTURE is a framing error, not data.
    assign w_take   = pix_valid && (r_state == ARM ? pix_sof : (r_state == CAPTURE && !pix_sof));
    assign w_esof   = pix_valid && pix_sof && r_state == CAPTURE;
    assign w_col_in = r_col < CW'(2 * FRAME_W);
    assign w_row_in = r_row < RW'(2 * FRAME_H);
    assign w_quad   = w_take && w_col_in && w_row_in && r_row[0] == ROW_BG && r_col[0] == COL_ODD;
    assign w_lb_we  = w_take && w_col_in && w_row_in && r_row[0] == ROW_GR && r_col[0] == COL_ODD;
    assign w_pop    = grab_enable && !pause && r_cnt != '0;
    assign w_full   = r_cnt == CNTW'(FIFO_DEPTH);
    assign w_wr     = r_push_v && (!w_full || w_pop);
    assign w_ovf    = r_push_v && w_full && !w_pop;

    bayer_line_buffer #(.FRAME_W(FRAME_W), .AW(LBW)) u_lb (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_addr  (LBW'(r_col >> 1)),
        .i_wdata ({r_evn, w_pix}),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ge_d       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_push_v     <= 1'b0;
            r_push_word  <= '0;
            r_sums_valid <= 1'b0;
            r_sum_r      <= '0;
            r_sum_g      <= '0;
            r_sum_b      <= '0;
            r_acc_r      <= '0;
            r_acc_g      <= '0;
            r_acc_b      <= '0;
            r_offset     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_pcnt       <= '0;
            r_evn        <= '0;
        end else if (!grab_enable) begin
            r_state      <= IDLE;
            r_ge_d       <= 1'b0;
            r_done       <= 1'b0;
            r_push_v     <= 1'b0;
            r_sums_valid <= 1'b0;
        end else begin
            r_ge_d       <= 1'b1;
            r_push_v     <= w_quad;
            r_push_word  <= {8'h00, r_evn, w_lb_rdata};
            r_sums_valid <= 1'b0;
            if (w_take) begin
                if (r_col[0] != COL_ODD) r_evn <= w_pix;
                r_col <= pix_eol ? '0 : r_col + CW'(w_col_in);
                if (pix_eol) r_row <= r_row + RW'(w_row_in);
            end
            if (w_wr) begin
                r_acc_r <= sat_add(r_acc_r, r_push_word[R_LSB +: 8]);
                r_acc_g <= sat_add(r_acc_g, r_push_word[G_LSB +: 8]);
                r_acc_b <= sat_add(r_acc_b, r_push_word[B_LSB +: 8]);
            end
            if (r_push_v) r_pcnt <= r_pcnt + PW'(1);
            if (w_ovf) r_err <= 1'b1;
            case (r_state)
                IDLE: if (!r_ge_d) begin
                    r_state  <= ARM;
                    r_offset <= data_write_offset;
                    r_col    <= '0;
                    r_row    <= '0;
                    r_pcnt   <= '0;
                    r_err    <= 1'b0;
                    r_acc_r  <= '0;
                    r_acc_g  <= '0;
                    r_acc_b  <= '0;
                end
                ARM: if (w_take) r_state <= CAPTURE;
                CAPTURE: if (w_esof || w_ovf) begin
                    r_state <= DONE;
                    r_err   <= 1'b1;
                end else if (r_push_v && r_pcnt == PW'(NQ - 1)) begin
                    r_state <= DRAIN;
                end
                DRAIN: if (r_cnt == '0 && !r_push_v) r_state <= DONE;
                DONE: if (!r_done) begin
                    r_done <= 1'b1;
                    if (!r_err) begin
                        r_sums_valid <= 1'b1;
                        r_sum_r      <= r_acc_r;
                        r_sum_g      <= r_acc_g;
                        r_sum_b      <= r_acc_b;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Writer: the ddr_* registers hold their last value while paused.
    always_ff @(posedge clk) begin
        if (reset || !grab_enable) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_wcnt <= '0;
            r_wren <= 1'b0;
            if (reset) begin
                r_ddr_addr <= '0;
                r_ddr_data <= '0;
            end
        end else begin
            if (w_pop) begin
                r_wren     <= 1'b1;
                r_ddr_data <= r_mem[r_rd];
                r_ddr_addr <= r_offset + r_wcnt;
                r_wcnt     <= r_wcnt + ADDR_W'(1);
                r_rd       <= r_rd + FAW'(1);
            end else if (!pause) begin
                r_wren <= 1'b0;
            end
            if (w_wr) r_wr <= r_wr + FAW'(1);
            r_cnt <= r_cnt + CNTW'(w_wr) - CNTW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= r_push_word;
    end

    assign ddr_addr       = r_ddr_addr;
    assign ddr_data_write = r_ddr_data;
    assign ddr_wren       = r_wren;
    assign grab_done      = r_done;
    assign frame_err      = r_err;
    assign sum_r          = r_sum_r;
    assign sum_g          = r_sum_g;
    assign sum_b          = r_sum_b;
    assign sums_valid     = r_sums_valid;
endmodule
